// File: rtl/cfg_loader.sv
// Configuration bitstream loader for the routing node array.
// It accepts a header byte (0xA5), then PB/8 payload bytes LSB-first, then one
// XOR checksum byte. A load is staged in a shadow register. The shadow is copied
// to prog only when the checksum matches, so the routing fabric never sees a
// partial or corrupt configuration.
module cfg_loader #(
  parameter int WIDTH  = 8,
  parameter int HEIGHT = 4,
  parameter int PB     = WIDTH * HEIGHT
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          cfg_start,
  input  logic [7:0]    cfg_data,
  input  logic          cfg_valid,
  output logic          cfg_ready,
  output logic [PB-1:0] prog,
  output logic          busy,
  output logic          cfg_done,
  output logic          cfg_err
);

  localparam int NBYTES = PB / 8;
  localparam int CW     = (NBYTES > 1) ? $clog2(NBYTES) : 1;
  localparam logic [CW-1:0] LAST_IDX = CW'(NBYTES - 1);
  localparam logic [7:0]    HDR_BYTE = 8'hA5;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_HDR  = 3'd1,
    S_LOAD = 3'd2,
    S_CHK  = 3'd3,
    S_DONE = 3'd4,
    S_ERR  = 3'd5
  } state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [PB-1:0]   shadow_q, shadow_d;
  logic [7:0]      xor_q, xor_d;
  logic [PB-1:0]   prog_q, prog_d;
  logic            xfer;

  // A byte moves only when both sides agree in the same cycle.
  assign xfer = cfg_valid & cfg_ready;

  // Register all state. Reset clears everything, which opens every route.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      shadow_q <= '0;
      xor_q    <= '0;
      prog_q   <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      shadow_q <= shadow_d;
      xor_q    <= xor_d;
      prog_q   <= prog_d;
    end
  end

  // Next-state logic. cfg_start overrides any byte arriving in the same cycle.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    shadow_d = shadow_q;
    xor_d    = xor_q;
    prog_d   = prog_q;
    if (cfg_start) begin
      state_d  = S_HDR;
      cnt_d    = '0;
      shadow_d = '0;
      xor_d    = '0;
    end else if (xfer) begin
      unique case (state_q)
        S_HDR: begin
          state_d = (cfg_data == HDR_BYTE) ? S_LOAD : S_ERR;
        end
        S_LOAD: begin
          for (int k = 0; k < NBYTES; k++) begin
            if (cnt_q == CW'(k)) shadow_d[8*k +: 8] = cfg_data;
          end
          xor_d = xor_q ^ cfg_data;
          if (cnt_q == LAST_IDX) begin
            state_d = S_CHK;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        S_CHK: begin
          if (cfg_data == xor_q) begin
            state_d = S_DONE;
            prog_d  = shadow_q;
          end else begin
            state_d = S_ERR;
          end
        end
        default: ;
      endcase
    end
  end

  // Status outputs decode directly from the state register.
  always_comb begin
    cfg_ready = (state_q == S_HDR) || (state_q == S_LOAD) || (state_q == S_CHK);
    busy      = cfg_ready;
    cfg_done  = (state_q == S_DONE);
    cfg_err   = (state_q == S_ERR);
    prog      = prog_q;
  end

endmodule

// File: tb/tb_cfg_loader.sv
// Bench for cfg_loader. A transaction-level model tracks each load from
// start to outcome: it counts accepted bytes, queues the payload, and decides
// commit or error from the header and the payload XOR.
module tb_cfg_loader;

  localparam int PB = 32;
  localparam int NB = PB / 8;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          cfg_start;
  logic [7:0]    cfg_data;
  logic          cfg_valid;
  logic          cfg_ready;
  logic [PB-1:0] prog;
  logic          busy;
  logic          cfg_done;
  logic          cfg_err;

  int checks = 0;
  int errors = 0;

  // Reference model state
  logic          m_busy, m_done, m_err;
  logic [PB-1:0] m_prog;
  int            m_cnt;
  logic [7:0]    m_bytes[$];

  cfg_loader dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .cfg_start(cfg_start),
    .cfg_data (cfg_data),
    .cfg_valid(cfg_valid),
    .cfg_ready(cfg_ready),
    .prog     (prog),
    .busy     (busy),
    .cfg_done (cfg_done),
    .cfg_err  (cfg_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [PB-1:0] obs, input logic [PB-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".prog"},  prog,                m_prog);
    chk({tag, ".ready"}, {31'd0, cfg_ready},  {31'd0, m_busy});
    chk({tag, ".busy"},  {31'd0, busy},       {31'd0, m_busy});
    chk({tag, ".done"},  {31'd0, cfg_done},   {31'd0, m_done});
    chk({tag, ".err"},   {31'd0, cfg_err},    {31'd0, m_err});
  endtask

  task automatic model_reset();
    m_busy = 1'b0; m_done = 1'b0; m_err = 1'b0;
    m_prog = '0; m_cnt = 0; m_bytes.delete();
  endtask

  // A load is header, NB payload bytes, then a checksum byte. The checksum
  // must equal the XOR of the payload. The payload is packed little-endian.
  task automatic model_step(input bit s, input bit v, input logic [7:0] d);
    logic [7:0] x;
    if (s) begin
      m_busy = 1'b1; m_done = 1'b0; m_err = 1'b0; m_cnt = 0; m_bytes.delete();
    end else if (m_busy && v) begin
      if (m_cnt == 0) begin
        if (d == 8'hA5) m_cnt = 1;
        else begin m_busy = 1'b0; m_err = 1'b1; end
      end else if (m_cnt <= NB) begin
        m_bytes.push_back(d);
        m_cnt++;
      end else begin
        x = 8'h00;
        foreach (m_bytes[i]) x = x ^ m_bytes[i];
        if (d == x) begin
          for (int k = 0; k < NB; k++) m_prog[8*k +: 8] = m_bytes[k];
          m_done = 1'b1;
        end else begin
          m_err = 1'b1;
        end
        m_busy = 1'b0;
      end
    end
  endtask

  task automatic tick(input bit s, input bit v, input logic [7:0] d, input string tag);
    cfg_start = s; cfg_valid = v; cfg_data = d;
    @(posedge clk);
    model_step(s, v, d);
    #1;
    $display("tick %-8s start=%0b valid=%0b data=%h -> prog=%h ready=%0b done=%0b err=%0b",
             tag, s, v, d, prog, cfg_ready, cfg_done, cfg_err);
    check_all(tag);
  endtask

  task automatic send_seq(input logic [7:0] seq[6], input string tag);
    for (int i = 0; i < 6; i++) tick(1'b0, 1'b1, seq[i], tag);
  endtask

  task automatic async_reset(input string tag);
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    $display("reset %-8s prog=%h ready=%0b done=%0b err=%0b", tag, prog, cfg_ready, cfg_done, cfg_err);
    check_all(tag);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  logic [7:0] s30[6] = '{8'hA5, 8'h01, 8'h02, 8'h04, 8'h08, 8'h0F};
  logic [7:0] s31[6] = '{8'hA5, 8'hFF, 8'h00, 8'hFF, 8'h00, 8'h33};
  logic [7:0] s34[6] = '{8'hA5, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'h00};
  logic [PB-1:0] k_prog30 = 32'h08040201;
  logic [PB-1:0] k_prog34 = 32'hFFFFFFFF;

  initial begin
    rst_n = 1'b0; cfg_start = 1'b0; cfg_valid = 1'b0; cfg_data = 8'h00;
    model_reset();
    #3;
    check_all("rst0");
    @(negedge clk);
    rst_n = 1'b1;

    // Bytes presented in IDLE must be ignored
    tick(1'b0, 1'b1, 8'hA5, "idle");

    // Back-to-back load of 08040201
    tick(1'b1, 1'b0, 8'h00, "r30");
    send_seq(s30, "r30");
    chk("r30.const", prog, k_prog30);

    // Bad checksum: error, prog kept
    tick(1'b1, 1'b0, 8'h00, "r31");
    send_seq(s31, "r31");
    chk("r31.const", prog, k_prog30);

    // Bad header, then bytes ignored
    tick(1'b1, 1'b0, 8'h00, "r32");
    tick(1'b0, 1'b1, 8'h5A, "r32");
    for (int i = 0; i < 3; i++) tick(1'b0, 1'b1, 8'hA5, "r32ign");

    // Valid toggled every cycle
    tick(1'b1, 1'b0, 8'h00, "r33");
    for (int i = 0; i < 6; i++) begin
      tick(1'b0, 1'b1, s30[i], "r33");
      tick(1'b0, 1'b0, 8'($urandom), "r33gap");
    end
    chk("r33.const", prog, k_prog30);

    // Restart mid-load, with the start coinciding with a transfer
    tick(1'b1, 1'b0, 8'h00, "r34");
    tick(1'b0, 1'b1, 8'hA5, "r34");
    tick(1'b0, 1'b1, 8'h11, "r34");
    tick(1'b0, 1'b1, 8'h22, "r34");
    tick(1'b1, 1'b1, 8'h5A, "r34st");
    send_seq(s34, "r34");
    chk("r34.const", prog, k_prog34);

    // Reset during a load
    tick(1'b1, 1'b0, 8'h00, "r35");
    tick(1'b0, 1'b1, 8'hA5, "r35");
    for (int i = 0; i < 3; i++) tick(1'b0, 1'b1, 8'h10 + 8'(i), "r35");
    async_reset("r35rst");
    tick(1'b0, 1'b1, 8'h40, "r35post");
    tick(1'b0, 1'b1, 8'h70, "r35post");

    // Randomized loads: gaps, bad headers, bad checksums, aborts, stray bytes
    for (int n = 0; n < 25; n++) begin
      logic [7:0] seq[6];
      logic [7:0] x;
      x = 8'h00;
      seq[0] = ($urandom_range(0, 9) == 0) ? 8'($urandom) : 8'hA5;
      for (int i = 1; i <= NB; i++) begin
        seq[i] = 8'($urandom);
        x = x ^ seq[i];
      end
      seq[5] = ($urandom_range(0, 3) == 0) ? (x ^ 8'($urandom_range(1, 255))) : x;
      tick(1'b1, 1'b0, 8'h00, "rnd");
      for (int i = 0; i < 6; i++) begin
        int gap;
        gap = $urandom_range(0, 2);
        for (int g = 0; g < gap; g++) tick(1'b0, 1'b0, 8'($urandom), "rndgap");
        if ($urandom_range(0, 29) == 0) tick(1'b1, 1'b0, 8'h00, "rndabort");
        tick(1'b0, 1'b1, seq[i], "rnd");
      end
      tick(1'b0, 1'b1, 8'($urandom), "rndpost");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/cfg_loader.md
CFG_LOADER -- requirements
Module: cfg_loader

Interface
REQ-001 Parameter WIDTH, default 8, vertical track count of the routing node array fed by this block.
REQ-002 Parameter HEIGHT, default 4, horizontal track count of the routing node array.
REQ-003 Parameter PB, default WIDTH*HEIGHT, total programming bit count; PB SHALL be a multiple of 8.
REQ-004 The block SHALL have one clock, clk; reset is asynchronous and active-low, rst_n.
REQ-005 clk  input  1  rising-edge clock for all state.
REQ-006 rst_n  input  1  asynchronous active-low reset.
REQ-007 cfg_start  input  1  one-cycle request to begin a configuration load.
REQ-008 cfg_data  input  8  bitstream byte.
REQ-009 cfg_valid  input  1  cfg_data is valid this cycle.
REQ-010 cfg_ready  output  1  block accepts a byte this cycle.
REQ-011 prog  output  PB  programming word driven to the Xnodes/Ynodes prog inputs.
REQ-012 busy  output  1  load in progress.
REQ-013 cfg_done  output  1  last load committed successfully (level).
REQ-014 cfg_err  output  1  last load failed (level).

Function
REQ-015 A transfer SHALL occur on a rising clk edge where cfg_valid=1 and cfg_ready=1; no other cycle consumes cfg_data.
REQ-016 States SHALL be IDLE, HDR, LOAD, CHK, DONE, ERR.
REQ-017 cfg_ready SHALL be 1 exactly in HDR, LOAD and CHK; busy SHALL equal cfg_ready.
REQ-018 cfg_start in any state SHALL enter HDR next cycle, clear byte counter, shadow register, running XOR, cfg_done and cfg_err; prog is not modified.
REQ-019 HDR: transferred byte 0xA5 -> LOAD; any other value -> ERR.
REQ-020 LOAD: byte k (k=0..PB/8-1) SHALL be written to shadow bits [8k+7:8k] (LSB-first) and XORed into the running checksum; after byte PB/8-1 -> CHK.
REQ-021 CHK: transferred byte equal to the running XOR -> DONE; otherwise -> ERR.
REQ-022 On the edge entering DONE, prog SHALL load the full shadow register atomically; prog is visible on the cycle after the checksum transfer.
REQ-023 prog SHALL never change except per REQ-022 and reset; no partial updates on error or abort.
REQ-024 DONE: cfg_done=1, cfg_err=0; ERR: cfg_err=1, cfg_done=0; both states hold until cfg_start or reset.
REQ-025 IDLE: cfg_done=0, cfg_err=0; cfg_valid is ignored in IDLE, DONE, ERR.
REQ-026 cfg_valid gaps of any length SHALL stall the sequence without losing state.
REQ-027 cfg_start coincident with a transfer: cfg_start wins, the byte is discarded.

Reset
REQ-028 rst_n=0 SHALL immediately force state IDLE, prog=0 (all routes open), counter/shadow/XOR=0, cfg_ready=0, busy=0, cfg_done=0, cfg_err=0.
REQ-029 Reset during a load SHALL abandon it; after release the block waits in IDLE for cfg_start.

Verification
REQ-030 cfg_start, then bytes A5,01,02,04,08,0F back-to-back -> prog=32'h08040201 one cycle after 0F, cfg_done=1, busy=0.
REQ-031 After REQ-030, load A5,FF,00,FF,00,33 -> cfg_err=1, prog remains 32'h08040201.
REQ-032 cfg_start, header 5A -> ERR after one byte, cfg_ready=0, prog unchanged; subsequent valid bytes ignored.
REQ-033 Load of 32'h08040201 with cfg_valid toggled 1/0 every cycle -> same result as REQ-030 after 12 cycles of stimulus.
REQ-034 cfg_start asserted after two payload bytes, then full sequence for 32'hFFFFFFFF (A5,FF,FF,FF,FF,00) -> prog=32'hFFFFFFFF, cfg_done=1.
REQ-035 rst_n pulled low after three payload bytes -> prog=0 and all outputs 0 immediately; no commit after release.
